fxp40s_shift_ctrl: RTL

// Upstream control stage for the FXP40S variable shifter. Accepts a stream of (data, signed FXP40S exponent, tag),

---
 rtl/fxp40s_pkg.sv | 20 ++
 rtl/fxp40s_skid_buf.sv | 90 +++++++++
 rtl/fxp40s_shift_ctrl.sv | 78 +++++++
 3 files changed

// File: rtl/fxp40s_pkg.sv
// -----------------------------------------------------------------------------
// fxp40s_pkg
// Shared definitions for the FXP40S fixed-point format: 40-bit two's
// complement value with 24 fractional bits (LSB = 2^-24).
// -----------------------------------------------------------------------------
package fxp40s_pkg;

    localparam int FXP40S_WIDTH   = 40;
    localparam int FXP40S_SIGN    = 39;
    localparam int FXP40S_LSB_POW = -24;
    localparam int FXP40S_INT_LSB = 24;
    localparam int SHIFT_SAT      = 64;

    // Integer part of |x| for a 40-bit value with 24 fraction bits.
    // It spans bits [40:24] of the 41-bit magnitude.
    localparam int SHIFT_MAG_W    = FXP40S_WIDTH + 1 - FXP40S_INT_LSB;

    typedef logic signed [FXP40S_WIDTH-1:0] fxp40s_t;

endpackage

// File: rtl/fxp40s_skid_buf.sv
// -----------------------------------------------------------------------------
// fxp40s_skid_buf
// Generic 2-entry valid/ready skid buffer. It gives full throughput, and
// s_ready is a register, so ready has no combinational path.
//   clk, rstn        clock, asynchronous active-low reset
//   s_valid/s_ready  upstream handshake, s_data payload [W-1:0]
//   m_valid/m_ready  downstream handshake, m_data payload [W-1:0]
// m_data comes straight from the main register. s_ready means "skid empty".
// -----------------------------------------------------------------------------
module fxp40s_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [W-1:0] s_data,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [W-1:0] m_data
);

    logic [W-1:0] main_q;
    logic [W-1:0] skid_q;
    logic         main_v;
    logic         skid_v;
    logic         ready_q;

    logic         accept;
    logic         load_main;
    logic         load_skid;
    logic         main_v_d;
    logic         skid_v_d;

    assign accept    = s_valid & ready_q;
    // The main register may change only when it is empty or its beat leaves this cycle.
    assign load_main = !main_v | m_ready;

    always_comb begin
        main_v_d  = main_v;
        skid_v_d  = skid_v;
        load_skid = 1'b0;
        if (load_main) begin
            // Only a beat that is already parked in the skid may enter main.
            // Otherwise the newly accepted beat enters main.
            if (skid_v) begin
                main_v_d = 1'b1;
                skid_v_d = 1'b0;
            end else begin
                main_v_d = accept;
            end
        end else if (accept) begin
            load_skid = 1'b1;
            skid_v_d  = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            main_v  <= 1'b0;
            skid_v  <= 1'b0;
            ready_q <= 1'b0;
            main_q  <= '0;
        end else begin
            main_v  <= main_v_d;
            skid_v  <= skid_v_d;
            ready_q <= !skid_v_d;
            if (load_main) begin
                if (skid_v) begin
                    main_q <= skid_q;
                end else if (accept) begin
                    main_q <= s_data;
                end
            end
        end
    end

    // NOTE: skid payload has no reset; skid_v alone decides whether it is meaningful.
    always_ff @(posedge clk) begin
        if (load_skid) begin
            skid_q <= s_data;
        end
    end

    assign s_ready = ready_q;
    assign m_valid = main_v;
    assign m_data  = main_q;

endmodule

// File: rtl/fxp40s_shift_ctrl.sv
// -----------------------------------------------------------------------------
// fxp40s_shift_ctrl
// Upstream control stage for the FXP40S variable shifter. It turns the signed
// FXP40S exponent into an unsigned shift magnitude and a direction, then
// registers them together with the data and the tag through a skid buffer.
//   clk, rstn               clock, asynchronous active-low reset
//   s_valid/s_ready         input handshake
//   s_data, s_exp, s_tag    value to shift, signed exponent, sideband tag
//   m_valid/m_ready         output handshake
//   m_data                  s_data, unchanged
//   m_shift                 |s_exp| integer part, zero-extended to 40 bits
//   m_shift_sign            0 = left shift, 1 = right shift
//   m_ovf                   magnitude >= 64, so the shifter zeroes its output
//   m_tag                   s_tag of this beat
// -----------------------------------------------------------------------------
module fxp40s_shift_ctrl
    import fxp40s_pkg::*;
#(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [39:0]      s_data,
    input  logic [39:0]      s_exp,
    input  logic [TAG_W-1:0] s_tag,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [39:0]      m_data,
    output logic [39:0]      m_shift,
    output logic             m_shift_sign,
    output logic             m_ovf,
    output logic [TAG_W-1:0] m_tag
);

    localparam int PAYLOAD_W = 2*FXP40S_WIDTH + 2 + TAG_W;

    fxp40s_t                   exp_s;
    logic [FXP40S_WIDTH:0]     abs_exp;
    logic [SHIFT_MAG_W-1:0]    mag;
    logic [FXP40S_WIDTH-1:0]   shift_dec;
    logic                      sign_dec;
    logic                      ovf_dec;
    logic [PAYLOAD_W-1:0]      in_payload;
    logic [PAYLOAD_W-1:0]      out_payload;

    assign exp_s = s_exp;

    // The magnitude is 41 bits wide, so -2^39 becomes +2^39 and does not wrap.
    assign abs_exp = exp_s[FXP40S_SIGN] ? -{exp_s[FXP40S_SIGN], exp_s}
                                        : {1'b0, exp_s};

    // Dropping the fraction bits truncates the magnitude toward zero.
    assign mag       = SHIFT_MAG_W'(abs_exp >> FXP40S_INT_LSB);
    assign shift_dec = {{(FXP40S_WIDTH-SHIFT_MAG_W){1'b0}}, mag};
    // A negative exponent smaller than 1.0 in magnitude becomes shift 0, which is reported as a left shift.
    assign sign_dec  = exp_s[FXP40S_SIGN] & (mag != '0);
    assign ovf_dec   = (mag >= SHIFT_MAG_W'(SHIFT_SAT));

    assign in_payload = {s_data, shift_dec, sign_dec, ovf_dec, s_tag};

    fxp40s_skid_buf #(
        .W (PAYLOAD_W)
    ) u_skid (
        .clk     (clk),
        .rstn    (rstn),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (in_payload),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (out_payload)
    );

    assign {m_data, m_shift, m_shift_sign, m_ovf, m_tag} = out_payload;

endmodule
